uart_transmitter: RTL and testbench

- Serialises parallel bytes onto one UART line: 8N1 by default, LSB first, idle-high.
- Transmit counterpart of the team's UART receiver. Same bit timing: 50 MHz clock, 115200 baud, 434 clocks per bit.
- Upstream logic (command/console source) hands bytes in through a valid/ready handshake.
- A one-entry holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_bit_timer.sv | 37 +++
 rtl/uart_transmitter.sv | 138 +++++++++++++
 tb/tb_uart_transmitter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing,
// common to the transmitter and the receiver.
package uart_pkg;

   localparam int BASE_FREQ            = 50_000_000;
   localparam int BAUDRATE             = 115_200;
   localparam int CLKS_PER_BIT_DEFAULT = BASE_FREQ / BAUDRATE;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: pulses bit_end_o on the last clock of every bit period
// while enabled; held at zero while cleared.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 434,
   parameter int CTR_WIDTH    = $clog2(CLKS_PER_BIT)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic bit_end_o
);

   localparam logic [CTR_WIDTH-1:0] LAST = CTR_WIDTH'(CLKS_PER_BIT - 1);

   logic [CTR_WIDTH-1:0] clk_ctr_q, clk_ctr_d;

   assign bit_end_o = enable_i && (clk_ctr_q == LAST);

   always_comb begin
      clk_ctr_d = clk_ctr_q;
      if (clear_i) begin
         clk_ctr_d = '0;
      end else if (enable_i) begin
         clk_ctr_d = bit_end_o ? '0 : clk_ctr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_ctr_q <= '0;
      end else begin
         clk_ctr_q <= clk_ctr_d;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, stop bit(s), idle-high line,
// valid/ready input with a one-entry holding register for gapless frames.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int CTR_WIDTH    = $clog2(CLKS_PER_BIT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 serial_data_out,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   logic [1:0]           state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic                 tx_q, tx_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 bit_end, accept, frame_end;
   logic [DATA_BITS-1:0] shifted;

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CTR_WIDTH    (CTR_WIDTH)
   ) u_bit_timer (
      .clk_i     (clk),
      .rst_ni    (rst),
      .clear_i   (state_q == IDLE),
      .enable_i  (state_q != IDLE),
      .bit_end_o (bit_end)
   );

   assign accept          = tx_valid && !hold_full_q;
   assign frame_end       = (state_q == STOP) && bit_end && (stop_idx_q == LAST_STOP);
   assign shifted         = shift_q >> 1;
   assign tx_ready        = !hold_full_q;
   assign tx_busy         = (state_q != IDLE);
   assign tx_done         = frame_end;
   assign serial_data_out = tx_q;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      tx_d        = tx_q;
      bit_idx_d   = bit_idx_q;
      stop_idx_d  = stop_idx_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d = tx_data;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_d      = shift_q[0];
               bit_idx_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx_q == LAST_BIT) begin
                  tx_d       = 1'b1;
                  stop_idx_d = 1'b0;
                  state_d    = STOP;
               end else begin
                  shift_d   = shifted;
                  tx_d      = shifted[0];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop_idx_q != LAST_STOP) begin
                  stop_idx_d = 1'b1;
               end else if (hold_full_q) begin
                  // Chain straight into the next start bit from the holding register.
                  shift_d     = hold_q;
                  hold_full_d = 1'b0;
                  tx_d        = 1'b0;
                  state_d     = START;
               end else if (accept) begin
                  shift_d = tx_data;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A byte accepted mid-frame parks in the holding register.
      if ((state_q != IDLE) && accept && !frame_end) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
         bit_idx_q   <= '0;
         stop_idx_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
         bit_idx_q   <= bit_idx_d;
         stop_idx_q  <= stop_idx_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      hold_q  <= hold_d;
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: directed frame tables, gapless/backpressure/reset
// sequences, randomized traffic against a line-decoding scoreboard, loopback.
module tb_uart_transmitter;

   localparam int CPB  = 8;
   localparam int CPBD = 434;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] a_data;  logic a_valid, a_ready, a_line, a_busy, a_done;
   logic [6:0] b_data;  logic b_valid, b_ready, b_line, b_busy, b_done;
   logic [7:0] c_data;  logic c_valid, c_ready, c_line, c_busy, c_done;

   uart_transmitter #(.CLKS_PER_BIT(CPB)) dut_a (
      .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
      .serial_data_out(a_line), .tx_busy(a_busy), .tx_done(a_done));

   uart_transmitter #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
      .serial_data_out(b_line), .tx_busy(b_busy), .tx_done(b_done));

   uart_transmitter dut_c (
      .clk(clk), .rst(rst), .tx_data(c_data), .tx_valid(c_valid), .tx_ready(c_ready),
      .serial_data_out(c_line), .tx_busy(c_busy), .tx_done(c_done));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: bytes accepted by dut_a, and a mid-bit line decoder.
   logic [7:0] exp_q[$];
   int   acc_cnt = 0;
   int   frm_cnt = 0;
   logic acc_seen = 1'b0;

   initial begin
      int   m_cnt, m_bit;
      logic m_busy;
      logic [7:0] m_byte, m_exp;
      m_busy = 1'b0; m_cnt = 0; m_byte = '0;
      forever begin
         @(negedge clk);
         acc_seen = 1'b0;
         if (rst !== 1'b1) begin
            m_busy = 1'b0;
            exp_q.delete();
         end else begin
            if (a_valid && a_ready) begin
               exp_q.push_back(a_data);
               acc_cnt++;
               acc_seen = 1'b1;
            end
            if (!m_busy) begin
               if (a_line === 1'b0) begin
                  m_busy = 1'b1;
                  m_cnt  = 0;
               end
            end else begin
               m_cnt++;
               if (m_cnt % CPB == CPB / 2) begin
                  m_bit = m_cnt / CPB;
                  if (m_bit == 0) begin
                     chk("mon_start_bit", 32'(a_line), 32'd0);
                  end else if (m_bit <= 8) begin
                     m_byte[m_bit-1] = a_line;
                  end else begin
                     chk("mon_stop_bit", 32'(a_line), 32'd1);
                     frm_cnt++;
                     m_busy = 1'b0;
                     chk("mon_frame_expected", 32'(exp_q.size() != 0), 32'd1);
                     if (exp_q.size() != 0) begin
                        m_exp = exp_q.pop_front();
                        chk("mon_byte", 32'(m_byte), 32'(m_exp));
                     end
                  end
               end
            end
         end
      end
   end

   task automatic wait_idle_a(input int limit);
      int n = 0;
      while (a_busy && n < limit) begin
         tick();
         n++;
      end
      chk("a_idle_timeout", 32'(a_busy), 32'd0);
   endtask

   // Called just after the accepting edge; checks the whole frame cycle by cycle.
   task automatic check_frame_a(input string name, input logic [9:0] frame);
      for (int k = 0; k < 10 * CPB; k++) begin
         chk({name, "_line"}, 32'(a_line), 32'(frame[k / CPB]));
         chk({name, "_busy"}, 32'(a_busy), 32'd1);
         chk({name, "_done"}, 32'(a_done), 32'(k == 10 * CPB - 1));
         tick();
      end
      chk({name, "_end_busy"}, 32'(a_busy), 32'd0);
      chk({name, "_end_line"}, 32'(a_line), 32'd1);
      chk({name, "_end_done"}, 32'(a_done), 32'd0);
   endtask

   task automatic accept_a(input logic [7:0] d);
      a_valid = 1'b1;
      a_data  = d;
      tick();
      chk("a_accept", 32'(acc_seen), 32'd1);
      a_valid = 1'b0;
      a_data  = 8'($urandom);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int n, a0, f0, guard;
      logic [9:0] fb;
      logic [7:0] got;
      logic [7:0] lvals[3];

      #200_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, a0, f0, guard;
      logic [9:0] fb;
      logic [7:0] got;
      logic [7:0] lvals[3];

      vecs[0] = '{data: 8'hA5, frame: 10'b1_10100101_0};
      vecs[1] = '{data: 8'h00, frame: 10'b1_00000000_0};
      vecs[2] = '{data: 8'hFF, frame: 10'b1_11111111_0};
      vecs[3] = '{data: 8'h3C, frame: 10'b1_00111100_0};
      lvals[0] = 8'h00; lvals[1] = 8'hFF; lvals[2] = 8'h3C;

      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
      a_data = '0; b_data = '0; c_data = '0;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst_a_line", 32'(a_line), 32'd1);
      chk("rst_a_ready", 32'(a_ready), 32'd1);
      chk("rst_a_busy", 32'(a_busy), 32'd0);
      chk("rst_a_done", 32'(a_done), 32'd0);
      chk("rst_b_line", 32'({b_line, b_ready, b_busy, b_done}), 32'b1100);
      chk("rst_c_line", 32'({c_line, c_ready, c_busy, c_done}), 32'b1100);
      repeat (3) tick();
      rst = 1'b1;
      repeat (2) tick();

      // Single frames from the vector table.
      foreach (vecs[i]) begin
         wait_idle_a(200);
         tick();
         accept_a(vecs[i].data);
         check_frame_a("single", vecs[i].frame);
      end

      // Back-to-back: second byte parks in the holding register.
      wait_idle_a(200);
      a_valid = 1'b1; a_data = 8'h55;
      tick();
      a_data = 8'h0F;
      tick();
      chk("b2b_second_accept", 32'(acc_seen), 32'd1);
      a_valid = 1'b0;
      for (int k = 1; k < 80; k++) begin
         chk("b2b_ready_low", 32'(a_ready), 32'd0);
         if (k == 79) begin
            chk("b2b_done_first", 32'(a_done), 32'd1);
            chk("b2b_stop_line", 32'(a_line), 32'd1);
         end
         tick();
      end
      chk("b2b_ready_back", 32'(a_ready), 32'd1);
      chk("b2b_no_gap_line", 32'(a_line), 32'd0);
      chk("b2b_busy", 32'(a_busy), 32'd1);
      for (int k = 80; k < 159; k++) tick();
      chk("b2b_done_second", 32'(a_done), 32'd1);
      tick();
      chk("b2b_idle", 32'(a_busy), 32'd0);

      // Direct accept on the final stop-bit edge with the holding register empty.
      tick();
      accept_a(8'h96);
      for (int k = 0; k < 79; k++) tick();
      chk("direct_done", 32'(a_done), 32'd1);
      a_valid = 1'b1; a_data = 8'h69;
      tick();
      chk("direct_accept", 32'(acc_seen), 32'd1);
      chk("direct_line", 32'(a_line), 32'd0);
      chk("direct_ready", 32'(a_ready), 32'd1);
      a_valid = 1'b0;
      wait_idle_a(200);

      // Backpressure: 0x33 waits while the holding register is full.
      a0 = acc_cnt; f0 = frm_cnt;
      tick();
      a_valid = 1'b1; a_data = 8'h11;
      tick();
      a_data = 8'h22;
      tick();
      a_data = 8'h33;
      n = 0;
      do begin
         tick();
         n++;
      end while (!acc_seen && n < 200);
      chk("bp_accept_delay", 32'(n), 32'd80);
      a_valid = 1'b0;
      wait_idle_a(400);
      repeat (4) tick();
      chk("bp_accept_count", 32'(acc_cnt - a0), 32'd3);
      chk("bp_frame_count", 32'(frm_cnt - f0), 32'd3);

      // Asynchronous reset during data bit 3, with a byte held.
      tick();
      accept_a(8'hC3);
      a_valid = 1'b1; a_data = 8'h5A;
      tick();
      a_valid = 1'b0;
      repeat (33) tick();
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_line", 32'(a_line), 32'd1);
      chk("rst_mid_busy", 32'(a_busy), 32'd0);
      chk("rst_mid_ready", 32'(a_ready), 32'd1);
      chk("rst_mid_done", 32'(a_done), 32'd0);
      tick(); tick();
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_held_dropped", 32'({a_busy, a_line}), 32'b01);
      accept_a(8'h81);
      check_frame_a("rst_recover", 10'b1_10000001_0);
      repeat (20) tick();
      chk("rst_recover_idle", 32'(a_busy), 32'd0);

      // Randomized traffic checked by the line decoder.
      a0 = acc_cnt; f0 = frm_cnt; guard = 0;
      while (acc_cnt - a0 < 40 && guard < 20000) begin
         tick();
         guard++;
         if (a_valid && acc_seen) a_valid = 1'b0;
         if (!a_valid) begin
            if ($urandom_range(0, 9) < 3) begin
               a_valid = 1'b1;
               a_data  = 8'($urandom);
            end else begin
               a_data = 8'($urandom);
            end
         end
      end
      a_valid = 1'b0;
      chk("rand_progress", 32'(guard < 20000), 32'd1);
      wait_idle_a(400);
      repeat (4) tick();
      chk("rand_frame_count", 32'(frm_cnt - f0), 32'(acc_cnt - a0));
      chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

      // 7 data bits, 2 stop bits.
      for (int v = 0; v < 2; v++) begin
         tick();
         b_valid = 1'b1;
         b_data  = (v == 0) ? 7'h7F : 7'h2A;
         fb      = {2'b11, b_data, 1'b0};
         tick();
         b_valid = 1'b0;
         for (int k = 0; k < 10 * CPB; k++) begin
            chk("b_line", 32'(b_line), 32'(fb[k / CPB]));
            chk("b_busy", 32'(b_busy), 32'd1);
            chk("b_done", 32'(b_done), 32'(k == 10 * CPB - 1));
            tick();
         end
         chk("b_end_idle", 32'({b_busy, b_line, b_ready}), 32'b011);
      end

      // Loopback at default timing through a mid-bit sampling receiver.
      foreach (lvals[i]) begin
         n = 0;
         while (c_busy && n < 5000) begin tick(); n++; end
         tick();
         c_valid = 1'b1; c_data = lvals[i];
         tick();
         c_valid = 1'b0;
         got = '0;
         for (int b = 0; b < 10; b++) begin
            repeat ((b == 0) ? CPBD / 2 : CPBD) tick();
            if (b == 0) chk("loop_start", 32'(c_line), 32'd0);
            else if (b <= 8) got[b-1] = c_line;
            else chk("loop_stop", 32'(c_line), 32'd1);
         end
         chk("loop_byte", 32'(got), 32'(lvals[i]));
      end
      n = 0;
      while (c_busy && n < 5000) begin tick(); n++; end
      chk("loop_idle", 32'(c_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
